ofdm_bitbuf_pingpong_ctrl: RTL and testbench

- Single-clock ping-pong controller for the 1-bit, dual-port modem bit buffer.
- The buffer is split into two banks of FRAME_LEN bits. Bank 0 starts at address 0 and bank 1 starts at address FRAME_LEN.
- Port A is the write side, filled from the upstream bit stream. Port B is the read side, drained to the downstream mapper with a valid/ready handshake.
- One bank can be filled while the other is drained. This gives continuous frame-by-frame flow between the scrambler/encoder and the symbol mapper.

---
 rtl/ofdm_bitbuf_pingpong_ctrl_if.sv | 30 +++
 rtl/ofdm_bitbuf_pingpong_ctrl.sv | 167 ++++++++++++++++
 tb/tb_ofdm_bitbuf_pingpong_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ofdm_bitbuf_pingpong_ctrl_if.sv
// Stream and buffer-port bundle for the OFDM ping-pong bit buffer controller.
// The controller attaches through the slave modport; the environment through master.
interface ofdm_bitbuf_pingpong_ctrl_if;
  logic       in_bit;
  logic       in_valid;
  logic       in_ready;
  logic       out_bit;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       buf_we_a;
  logic [8:0] buf_addr_a;
  logic       buf_din_a;
  logic       buf_we_b;
  logic [8:0] buf_addr_b;
  logic       buf_dout_b;
  logic [1:0] bank_full;

  modport master (
    output in_bit, in_valid, out_ready, buf_dout_b,
    input  in_ready, out_bit, out_valid, out_last,
    input  buf_we_a, buf_addr_a, buf_din_a, buf_we_b, buf_addr_b, bank_full
  );

  modport slave (
    input  in_bit, in_valid, out_ready, buf_dout_b,
    output in_ready, out_bit, out_valid, out_last,
    output buf_we_a, buf_addr_a, buf_din_a, buf_we_b, buf_addr_b, bank_full
  );
endinterface

// File: rtl/ofdm_bitbuf_pingpong_ctrl.sv
// Ping-pong controller for a 1-bit dual-port frame buffer: port A fills one bank while
// port B drains the other. Define OFDM_BITBUF_INTERLEAVE_EN for column-major readout.
module ofdm_bitbuf_pingpong_ctrl #(
  parameter int FRAME_LEN = 256,
  parameter int ROWS      = 16
) (
  input logic                        clk,
  input logic                        rst,
  ofdm_bitbuf_pingpong_ctrl_if.slave bus
);

  localparam int            AW       = 9;
  localparam logic [AW-1:0] FL_A     = AW'(FRAME_LEN);
  localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);

  if ((2 * FRAME_LEN > 512) || (FRAME_LEN % ROWS != 0)) begin : g_param_check
    $error("ofdm_bitbuf_pingpong_ctrl: FRAME_LEN/ROWS out of range");
  end

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;

  bank_state_e   bank_st     [2];
  bank_state_e   bank_st_nxt [2];
  logic          wbank, rbank, fbank, wbank_nxt;
  logic [AW-1:0] wcnt, rcnt;
  logic          in_ready_q, in_ready_d;
  logic          rd_pend, rd_pend_last;
  logic [1:0]    fifo_bit, fifo_last;
  logic          fifo_wp, fifo_rp;
  logic [1:0]    fifo_cnt;
  logic          fifo_nonempty;

  logic          wr_fire, wr_end;
  logic          rd_active, rd_issue, rd_end;
  logic          pop, last_pop;
  logic [2:0]    occ;
  logic [AW-1:0] wbase, rbase, raddr;

  assign wr_fire = bus.in_valid & in_ready_q;
  assign wr_end  = wr_fire && (wcnt == LAST_IDX);
  assign wbase   = wbank ? FL_A : '0;
  assign rbase   = rbank ? FL_A : '0;

  assign fifo_nonempty = (fifo_cnt != 2'd0);
  assign pop           = fifo_nonempty && bus.out_ready;
  assign last_pop      = pop && fifo_last[fifo_rp];

  // A bank is readable in the cycle the reader selects it, so the first read
  // leaves one cycle after the last write and data shows two cycles after FULL.
  assign rd_active = (bank_st[rbank] == FULL) || (bank_st[rbank] == DRAINING);
  // Credit the pop happening this cycle so the pipeline sustains 1 bit/cycle.
  assign occ       = {1'b0, fifo_cnt} + {2'b00, rd_pend} - {2'b00, pop};
  assign rd_issue  = rd_active && (occ < 3'd2);
  assign rd_end    = rd_issue && (rcnt == LAST_IDX);

`ifdef OFDM_BITBUF_INTERLEAVE_EN
  localparam int            COLS     = FRAME_LEN / ROWS;
  localparam logic [AW-1:0] COLS_A   = AW'(COLS);
  localparam logic [AW-1:0] ROW_LAST = AW'(ROWS - 1);

  logic [AW-1:0] row, row_off, col;

  // row_off tracks row*COLS incrementally so no multiplier or divider is needed.
  assign raddr = rbase + row_off + col;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row     <= '0;
      row_off <= '0;
      col     <= '0;
    end else if (rd_issue) begin
      if (rd_end) begin
        row     <= '0;
        row_off <= '0;
        col     <= '0;
      end else if (row == ROW_LAST) begin
        row     <= '0;
        row_off <= '0;
        col     <= col + 1'b1;
      end else begin
        row     <= row + 1'b1;
        row_off <= row_off + COLS_A;
      end
    end
  end
`else
  assign raddr = rbase + rcnt;
`endif

  // NOTE: every signal written here gets a default first; a missed path would infer a latch.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      bank_st_nxt[i] = bank_st[i];
      if (wbank == 1'(i)) begin
        if (wr_fire)
          bank_st_nxt[i] = (wcnt == LAST_IDX) ? FULL : FILLING;
        else if (bank_st[i] == EMPTY)
          bank_st_nxt[i] = FILLING;
      end
      if ((rbank == 1'(i)) && (bank_st[i] == FULL))
        bank_st_nxt[i] = DRAINING;
      if ((fbank == 1'(i)) && last_pop)
        bank_st_nxt[i] = EMPTY;
    end
    wbank_nxt  = wbank ^ wr_end;
    in_ready_d = (bank_st_nxt[wbank_nxt] == EMPTY) || (bank_st_nxt[wbank_nxt] == FILLING);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_st[0]   <= EMPTY;
      bank_st[1]   <= EMPTY;
      wbank        <= 1'b0;
      rbank        <= 1'b0;
      fbank        <= 1'b0;
      wcnt         <= '0;
      rcnt         <= '0;
      in_ready_q   <= 1'b0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
      fifo_wp      <= 1'b0;
      fifo_rp      <= 1'b0;
      fifo_cnt     <= 2'd0;
    end else begin
      bank_st[0]   <= bank_st_nxt[0];
      bank_st[1]   <= bank_st_nxt[1];
      wbank        <= wbank_nxt;
      in_ready_q   <= in_ready_d;
      if (wr_fire)
        wcnt <= wr_end ? '0 : wcnt + 1'b1;
      if (rd_issue)
        rcnt <= rd_end ? '0 : rcnt + 1'b1;
      rbank        <= rbank ^ rd_end;
      // fbank follows the older draining bank; banks always retire in write order.
      fbank        <= fbank ^ last_pop;
      rd_pend      <= rd_issue;
      rd_pend_last <= rd_end;
      if (rd_pend)
        fifo_wp <= ~fifo_wp;
      if (pop)
        fifo_rp <= ~fifo_rp;
      fifo_cnt     <= fifo_cnt + {1'b0, rd_pend} - {1'b0, pop};
    end
  end

  // NOTE: FIFO storage is not reset; entries are only visible through fifo_cnt, which is.
  always_ff @(posedge clk) begin
    if (rd_pend) begin
      fifo_bit[fifo_wp]  <= bus.buf_dout_b;
      fifo_last[fifo_wp] <= rd_pend_last;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.buf_we_a   = wr_fire;
  assign bus.buf_addr_a = wbase + wcnt;
  assign bus.buf_din_a  = wr_fire & bus.in_bit;
  assign bus.buf_we_b   = 1'b0;
  assign bus.buf_addr_b = raddr;
  assign bus.out_valid  = fifo_nonempty;
  assign bus.out_bit    = fifo_nonempty & fifo_bit[fifo_rp];
  assign bus.out_last   = fifo_nonempty & fifo_last[fifo_rp];
  assign bus.bank_full  = {(bank_st[1] == FULL) || (bank_st[1] == DRAINING),
                           (bank_st[0] == FULL) || (bank_st[0] == DRAINING)};

endmodule

// File: tb/tb_ofdm_bitbuf_pingpong_ctrl.sv
// Scoreboard bench for ofdm_bitbuf_pingpong_ctrl: completed frames queue their expected
// readout order; a negedge monitor checks every write and every output handshake.
module tb_ofdm_bitbuf_pingpong_ctrl;
  localparam int FL     = 256;
  localparam int ROWS   = 16;
  localparam int COLS   = FL / ROWS;
  localparam int BUDGET = 4000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ofdm_bitbuf_pingpong_ctrl_if bus ();

  ofdm_bitbuf_pingpong_ctrl #(.FRAME_LEN(FL), .ROWS(ROWS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural 512x1 dual-port buffer, read data one cycle after address.
  logic mem [512];
  always @(posedge clk) begin
    if (bus.buf_we_a) mem[bus.buf_addr_a] <= bus.buf_din_a;
    bus.buf_dout_b <= mem[bus.buf_addr_b];
  end

  int         n_vec = 0;
  int         n_err = 0;
  logic [1:0] exp_q [$];
  logic       frame_bits [FL];
  int         widx = 0;
  logic       wsel = 1'b0;
  int         last_cnt = 0;
  int         stall_cnt = 0;
  bit         count_stalls = 1'b0;
  bit         rnd_mode = 1'b0;
  bit         abort = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic pat(input int k, input int mode);
    logic [31:0] v;
    v = k;
    return (mode == 0) ? v[0] : (v[0] ^ v[2] ^ v[5] ^ v[8]);
  endfunction

  // Monitor / scoreboard
  initial begin
    logic [1:0] e;
    int idx;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        widx = 0;
        wsel = 1'b0;
        continue;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_out: got bit %0b with empty scoreboard (t=%0t)", bus.out_bit, $time);
        end else begin
          e = exp_q.pop_front();
          check("out_bit", bus.out_bit, e[1]);
          check("out_last", bus.out_last, e[0]);
        end
        if (bus.out_last) last_cnt++;
      end
      if (bus.in_valid && bus.in_ready) begin
        check("we_a", bus.buf_we_a, 1);
        check("addr_a", bus.buf_addr_a, (wsel ? FL : 0) + widx);
        check("din_a", bus.buf_din_a, bus.in_bit);
        frame_bits[widx] = bus.in_bit;
        widx++;
        if (widx == FL) begin
          for (int j = 0; j < FL; j++) begin
`ifdef OFDM_BITBUF_INTERLEAVE_EN
            idx = (j % ROWS) * COLS + (j / ROWS);
`else
            idx = j;
`endif
            exp_q.push_back({frame_bits[idx], (j == FL - 1)});
          end
          widx = 0;
          wsel = ~wsel;
        end
      end else if (bus.in_valid) begin
        check("we_a_blocked", bus.buf_we_a, 0);
        if (count_stalls) stall_cnt++;
      end
    end
  end

  // Random downstream back-pressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_mode) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b);
    int  n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    if (abort) return;
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < BUDGET);
    if (!acc) begin
      n_vec++;
      n_err++;
      abort = 1'b1;
      $display("FAIL send_timeout: in_ready low for %0d cycles", n);
    end
  endtask

  task automatic send_stream(input int first, input int nbits, input int gap_every, input int mode);
    for (int k = first; k < first + nbits; k++) begin
      if (gap_every > 0 && k > 0 && (k % gap_every) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      if (k == FL) count_stalls = count_stalls | (gap_every > 0);
      send_bit(pat(k, mode));
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_last"}, bus.out_last, 0);
    check({tag, "_out_bit"}, bus.out_bit, 0);
    check({tag, "_we_a"}, bus.buf_we_a, 0);
    check({tag, "_addr_a"}, bus.buf_addr_a, 0);
    check({tag, "_din_a"}, bus.buf_din_a, 0);
    check({tag, "_we_b"}, bus.buf_we_b, 0);
    check({tag, "_addr_b"}, bus.buf_addr_b, 0);
    check({tag, "_bank_full"}, bus.bank_full, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int lc0;
    int n;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", bus.in_ready, 1);

    // Single frame: FULL one cycle after the last write, out_valid two cycles after FULL.
    bus.out_ready = 1'b1;
    send_stream(0, FL, 0, 0);
    check("bank_full_after_frame", bus.bank_full, 2'b01);
    check("out_valid_t1", bus.out_valid, 0);
    @(posedge clk);
    #1;
    check("out_valid_t2", bus.out_valid, 0);
    @(posedge clk);
    #1;
    check("out_valid_t3", bus.out_valid, 1);
    drain("drain_frame0");
    check("last_count_frame0", last_cnt, 1);

    // Four frames back to back with light input gaps; writer must never stall after frame 0.
    lc0 = last_cnt;
    stall_cnt = 0;
    send_stream(0, 4 * FL, 32, 1);
    count_stalls = 1'b0;
    check("in_ready_stalls", stall_cnt, 0);
    drain("drain_stream");
    check("last_count_stream", last_cnt - lc0, 4);

    // Both banks full under back-pressure; the 513th bit must wait for bank 0 to free.
    do_reset();
    bus.out_ready = 1'b0;
    lc0 = last_cnt;
    send_stream(0, 2 * FL, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("bank_full_both", bus.bank_full, 2'b11);
    check("in_ready_both_full", bus.in_ready, 0);
    check("out_valid_stalled", bus.out_valid, 1);
    bus.in_valid = 1'b1;
    bus.in_bit   = 1'b1;
    repeat (4) @(negedge clk);
    check("we_a_513th", bus.buf_we_a, 0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.out_valid && bus.out_ready && bus.out_last) && n < BUDGET);
    check("bank0_last_seen", n < BUDGET, 1);
    check("in_ready_at_last", bus.in_ready, 0);
    @(negedge clk);
    check("in_ready_after_last", bus.in_ready, 1);
    check("addr_513th", bus.buf_addr_a, 0);
    @(posedge clk);
    #1;
    send_stream(1, FL - 1, 0, 0);
    drain("drain_backpressure");
    check("last_count_backpressure", last_cnt - lc0, 3);

    // Random downstream ready over four frames.
    lc0 = last_cnt;
    rnd_mode = 1'b1;
    send_stream(0, 4 * FL, 0, 1);
    drain("drain_random");
    rnd_mode = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    check("last_count_random", last_cnt - lc0, 4);

    // Reset in the middle of frame 0 discards the partial frame.
    do_reset();
    lc0 = last_cnt;
    send_stream(0, 100, 0, 0);
    bus.in_valid = 1'b1;
    bus.in_bit   = pat(100, 0);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("out_valid_after_midrst", bus.out_valid, 0);
    @(posedge clk);
    #1;
    send_stream(0, FL, 0, 1);
    drain("drain_after_midrst");
    check("last_count_after_midrst", last_cnt - lc0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
